// File: rtl/serial_and16.sv
// serial_and16: bit-serial a&b, one bit per clock LSB first; ports clk, reset, in_valid/in_ready/a/b in, out_valid/out_ready/out result, busy while shifting
module serial_and16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_out;
  logic [CW-1:0] r_cnt;
  logic w_bit;
  logic [WIDTH-1:0] w_res_next;
  assign w_bit = r_a[0] & r_b[0];
  assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
  assign in_ready = r_state == IDLE;
  assign busy = r_state == SHIFT;
  assign out_valid = r_state == DONE;
  assign out = r_out;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_res <= '0;
      r_out <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a <= a;
          r_b <= b;
          r_res <= '0;
          r_cnt <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_a <= r_a >> 1;
          r_b <= r_b >> 1;
          r_res <= w_res_next;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_out <= w_res_next;
            r_state <= DONE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_and16.sv
// tb_serial_and16: random and directed checks of serial_and16 against a cycle-level reference model
module tb_serial_and16;
  localparam int W = 16;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [W-1:0] a = 0, b = 0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] out;
  int tests = 0, fails = 0;
  int cyc = 0, nbusy = 0, acc_cyc = 0, nacc = 0, ndel = 0;
  bit started = 0, rnd_done = 0;
  int m_mode = 0, m_left = 0;
  logic [W-1:0] m_res = 0, m_out = 0;
  logic [W-1:0] q[$];

  serial_and16 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: mode 0 waiting, 1 computing for W cycles, 2 holding result
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_mode <= 0;
      m_left <= 0;
      m_out <= '0;
      q.delete();
    end else if (m_mode == 0) begin
      if (in_valid) begin
        m_mode <= 1;
        m_left <= W;
        m_res <= a & b;
        q.push_back(a & b);
        nacc <= nacc + 1;
      end
    end else if (m_mode == 1) begin
      if (m_left == 1) begin
        m_mode <= 2;
        m_out <= m_res;
      end else m_left <= m_left - 1;
    end else if (out_ready) m_mode <= 0;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, m_mode == 0);
      chk("busy", busy, m_mode == 1);
      chk("out_valid", out_valid, m_mode == 2);
      chk("out", out, m_out);
      if (busy) nbusy++;
      if (out_valid && out_ready && !reset) begin
        ndel++;
        if (q.size() == 0) chk("scoreboard_empty", 1, 0);
        else chk("order", out, q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb);
    bit acc;
    int n = 0;
    in_valid = 1;
    a = xa;
    b = xb;
    do begin
      acc = in_ready;
      step(1);
      n++;
    end while (!acc && n < 500);
    if (!acc) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    in_valid = 0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 100) begin
      step(1);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  initial begin
    logic [W-1:0] hold;
    step(3);
    started = 1;
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", out, 0);

    out_ready = 1;
    nbusy = 0;
    send(16'hFFFF, 16'h00FF);
    wait_out();
    chk("latency", cyc - acc_cyc, 16);
    step(1);
    chk("busy_cycles", nbusy, 16);
    chk("and_ff_00ff", out, 16'h00FF);
    chk("idle_after", in_ready, 1);

    send(16'hAAAA, 16'h5555);
    wait_out();
    chk("and_aaaa_5555", out, 16'h0000);
    step(1);
    send(16'h1234, 16'hFFFF);
    wait_out();
    chk("and_1234", out, 16'h1234);
    step(1);

    out_ready = 0;
    send(16'hC3C3, 16'h0FF0);
    wait_out();
    hold = out;
    chk("bp_value", hold, 16'h03C0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_out", out, hold);
      chk("bp_in_ready", in_ready, 0);
      step(1);
    end
    out_ready = 1;
    step(1);
    chk("bp_release", in_ready, 1);
    chk("bp_out_kept", out, 16'h03C0);

    out_ready = 0;
    send(16'hF00F, 16'h3CC3);
    in_valid = 1;
    for (int i = 0; i < 18; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      step(1);
    end
    in_valid = 0;
    wait_out();
    chk("ignore_inputs", out, 16'h3003);
    out_ready = 1;
    step(1);

    send(16'h5A5A, 16'hFFFF);
    step(6);
    reset = 1;
    step(1);
    reset = 0;
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_out", out, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", out_valid, 0);
    step(20);
    chk("rst_no_valid", out_valid, 0);
    send(16'h0F0F, 16'h00FF);
    wait_out();
    chk("after_reset", out, 16'h000F);
    step(1);

    nacc = 0;
    ndel = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          step($urandom_range(0, 3));
          send(W'($urandom), W'($urandom));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = $urandom_range(0, 3) != 0;
          step(1);
        end
      end
    join
    out_ready = 1;
    step(40);
    chk("drain_queue", q.size(), 0);
    chk("rand_accepted", nacc, 1000);
    chk("rand_delivered", ndel, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
